// File: rtl/ped_signal_if.sv
// Pedestrian signal controller bus: sequencer/button/timebase inputs and lamp/status outputs.
interface ped_signal_if #(
   parameter int unsigned CNT_W = 4
);
   logic [1:0]       light;
   logic             ped_btn;
   logic             tick;
   logic             walk;
   logic             dont_walk;
   logic             ped_active;
   logic [CNT_W-1:0] countdown;
   logic             req_pending;
   logic             conflict;

   modport master (
      output light, ped_btn, tick,
      input  walk, dont_walk, ped_active, countdown, req_pending, conflict
   );

   modport slave (
      input  light, ped_btn, tick,
      output walk, dont_walk, ped_active, countdown, req_pending, conflict
   );
endinterface

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: latches button requests, runs WALK then flashing CLEAR
// while the vehicle light is Red, and aborts with a sticky conflict flag otherwise.
module ped_signal_ctrl #(
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned WALK_TICKS  = 8,
   parameter int unsigned FLASH_TICKS = 6
) (
   input logic         clk,
   input logic         reset_n,
   ped_signal_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WALK  = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   localparam logic [1:0] LIGHT_RED = 2'b00;
   localparam logic [1:0] LIGHT_BAD = 2'b11;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flash_q, flash_d;
   logic             req_q, req_d;
   logic             conflict_q, conflict_d;
   logic             btn_prev_q, btn_prev_d;
   logic             btn_rise;
   logic             light_red;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         flash_q    <= 1'b1;
         req_q      <= 1'b0;
         conflict_q <= 1'b0;
         btn_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         flash_q    <= flash_d;
         req_q      <= req_d;
         conflict_q <= conflict_d;
         btn_prev_q <= btn_prev_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      flash_d    = flash_q;
      req_d      = req_q;
      conflict_d = conflict_q;
      btn_prev_d = bus.ped_btn;
      btn_rise   = bus.ped_btn & ~btn_prev_q;
      light_red  = (bus.light == LIGHT_RED);

      if (bus.light == LIGHT_BAD) conflict_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (req_q && light_red) begin
               state_d = ST_WALK;
               cnt_d   = CNT_W'(WALK_TICKS);
               req_d   = 1'b0;
            end
         end
         ST_WALK: begin
            if (!light_red) begin
               state_d    = ST_IDLE;
               cnt_d      = '0;
               conflict_d = 1'b1;
            end else if (bus.tick) begin
               if (cnt_q > CNT_W'(1)) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  state_d = ST_CLEAR;
                  cnt_d   = CNT_W'(FLASH_TICKS);
                  flash_d = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            if (!light_red) begin
               state_d    = ST_IDLE;
               cnt_d      = '0;
               conflict_d = 1'b1;
            end else if (bus.tick) begin
               flash_d = ~flash_q;
               if (cnt_q > CNT_W'(1)) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // A fresh press always wins over the service-time clear
      if (btn_rise) req_d = 1'b1;
   end

   assign bus.walk        = (state_q == ST_WALK);
   assign bus.dont_walk   = (state_q == ST_IDLE) | ((state_q == ST_CLEAR) & flash_q);
   assign bus.ped_active  = (state_q == ST_WALK) | (state_q == ST_CLEAR);
   assign bus.countdown   = cnt_q;
   assign bus.req_pending = req_q;
   assign bus.conflict    = conflict_q;
endmodule
